// File: rtl/seq_loader.sv
// Streams a signed sample burst into memory, appends the sample count at the top address,
// then kicks the sorter and waits for it to finish.
//
// state | meaning
// LOAD  | accept samples, write each to address = running count
// WSIZE | burst closed; queue the size-word write at the top address
// START | one-cycle Start pulse to the sorter
// WAIT  | wait for the sorter's Finish level
// DONE  | sort complete, terminal until reset
// ERR   | burst rejected (fewer than 2 samples), terminal until reset
module seq_loader #(
  parameter int dataWidth = 32,
  parameter int addrWidth = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [dataWidth-1:0] in_data,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic        [addrWidth-1:0] WAddr,
  output logic signed [dataWidth-1:0] WData,
  output logic                        Wen,
  output logic                        mem_sel,
  output logic                        Start,
  input  logic                        Finish,
  output logic                        done,
  output logic                        err,
  output logic                        ovf,
  output logic        [addrWidth-1:0] count
);

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_WSIZE = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [addrWidth-1:0] ADDR_TOP = '1;
  localparam logic [addrWidth-1:0] CAP_LAST = ADDR_TOP - 1'b1;

  logic [2:0] state;
  logic       hs;

  assign in_ready = (state == S_LOAD) && (count != ADDR_TOP);
  assign hs       = in_valid && in_ready;
  assign Start    = (state == S_START);
  assign done     = (state == S_DONE);
  assign err      = (state == S_ERR);
  // The registered size write lands while the FSM is already in START, so ownership
  // of the memory port stretches to cover any write still in flight.
  assign mem_sel  = (state == S_LOAD) || (state == S_WSIZE) || Wen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_LOAD;
      count <= '0;
      Wen   <= 1'b0;
      WAddr <= '0;
      WData <= '0;
      ovf   <= 1'b0;
    end else begin
      Wen <= 1'b0;
      case (state)
        S_LOAD: begin
          if (hs) begin
            if (in_last && (count == '0)) begin
              state <= S_ERR;
            end else begin
              Wen   <= 1'b1;
              WAddr <= count;
              WData <= in_data;
              count <= count + 1'b1;
              if (in_last || (count == CAP_LAST)) state <= S_WSIZE;
              if ((count == CAP_LAST) && !in_last) ovf <= 1'b1;
            end
          end
        end
        S_WSIZE: begin
          Wen   <= 1'b1;
          WAddr <= ADDR_TOP;
          WData <= dataWidth'(count);
          state <= S_START;
        end
        S_START: state <= S_WAIT;
        S_WAIT:  if (Finish) state <= S_DONE;
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_loader.sv
// Self-checking bench for seq_loader: expected memory writes are queued as samples are
// driven and matched against the write port as it fires.
module tb_seq_loader;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [31:0] in_data = '0;
  logic               in_last = 1'b0;
  logic               in_ready;
  logic        [9:0]  WAddr;
  logic signed [31:0] WData;
  logic               Wen;
  logic               mem_sel;
  logic               Start;
  logic               Finish = 1'b0;
  logic               done;
  logic               err;
  logic               ovf;
  logic        [9:0]  count;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  logic [41:0] exp_q[$];

  seq_loader #(.dataWidth(32), .addrWidth(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .WAddr(WAddr), .WData(WData), .Wen(Wen), .mem_sel(mem_sel),
    .Start(Start), .Finish(Finish), .done(done), .err(err), .ovf(ovf), .count(count)
  );

  always #5 clk = ~clk;

  // write-port monitor / scoreboard consumer
  always @(negedge clk) begin
    if (!rst) begin
      if (Start) start_cnt++;
      if (Wen) begin
        logic [41:0] e;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_write: addr=%0d data=%0d, no write expected", WAddr, WData);
        end else begin
          e = exp_q.pop_front();
          if ({WAddr, WData} !== e) begin
            errors++;
            $display("FAIL write: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                     WAddr, WData, e[41:32], $signed(e[31:0]));
          end
        end
        checks++;
        if (mem_sel !== 1'b1) begin
          errors++;
          $display("FAIL mem_sel_during_write: got %b expected 1", mem_sel);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; Finish = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    start_cnt = 0;
    rst = 1'b0;
  endtask

  // drive one sample (caller is at posedge+#1); returns at the cycle after the handshake
  task automatic send(input logic signed [31:0] d, input logic l, input bit wr, input logic [9:0] a);
    in_valid = 1'b1; in_data = d; in_last = l;
    if (wr) exp_q.push_back({a, d});
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_load: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (!(start_cnt > 0 && exp_q.size() == 0) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL %s_timeout: start_cnt=%0d pending_writes=%0d, expected Start and no pending",
               tag, start_cnt, exp_q.size());
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (start_cnt !== 1) begin
      errors++;
      $display("FAIL %s_start_pulses: got %0d expected 1", tag, start_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if ({Wen, WAddr, WData, Start, done, err, ovf, mem_sel, count} !== {1'b0, 10'd0, 32'd0, 4'b0000, 1'b1, 10'd0}) begin
      errors++;
      $display("FAIL reset_outputs: Wen=%b WAddr=%0d WData=%0d Start=%b done=%b err=%b ovf=%b mem_sel=%b count=%0d",
               Wen, WAddr, WData, Start, done, err, ovf, mem_sel, count);
    end
    do_reset();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_burst();
    logic signed [31:0] v[5];
    v = '{32'sd5, -32'sd3, 32'sd7, 32'sd0, -32'sd1};
    do_reset();
    for (int i = 0; i < 5; i++) send(v[i], i == 4, 1'b1, 10'(i));
    exp_q.push_back({10'd1023, 32'd5});
    wait_start("burst");
    checks++;
    if (count !== 10'd5 || ovf !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL burst_status: count=%0d ovf=%b done=%b expected 5 0 0", count, ovf, done);
    end
  endtask

  task automatic test_single();
    do_reset();
    send(32'sd9, 1'b1, 1'b0, 10'd0);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1 || in_ready !== 1'b0 || start_cnt !== 0 || done !== 1'b0) begin
      errors++;
      $display("FAIL single_err: err=%b in_ready=%b starts=%0d done=%b expected 1 0 0 0",
               err, in_ready, start_cnt, done);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 1023; i++) send(32'(i * 3 - 500), 1'b0, 1'b1, 10'(i));
    exp_q.push_back({10'd1023, 32'd1023});
    wait_start("ovf");
    checks++;
    if (ovf !== 1'b1 || count !== 10'd1023 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ovf_status: ovf=%b count=%0d in_ready=%b expected 1 1023 0", ovf, count, in_ready);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(32'(100 + i), i == 2, 1'b1, 10'(i));
      if (i < 2) begin
        repeat (2) @(posedge clk);
        #1;
      end
    end
    exp_q.push_back({10'd1023, 32'd3});
    wait_start("gaps");
    checks++;
    if (count !== 10'd3) begin
      errors++;
      $display("FAIL gaps_count: got %0d expected 3", count);
    end
  endtask

  task automatic test_finish();
    do_reset();
    send(-32'sd20, 1'b0, 1'b1, 10'd0);
    Finish = 1'b1;
    @(posedge clk); #1;
    Finish = 1'b0;
    checks++;
    if (done !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL finish_in_load: done=%b in_ready=%b expected 0 1", done, in_ready);
    end
    send(32'sd30, 1'b0, 1'b1, 10'd1);
    send(32'sd40, 1'b1, 1'b1, 10'd2);
    exp_q.push_back({10'd1023, 32'd3});
    wait_start("finish");
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL finish_wait_early: done=%b expected 0", done);
    end
    Finish = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b0 || Wen !== 1'b0 || Start !== 1'b0) begin
      errors++;
      $display("FAIL finish_done: done=%b in_ready=%b Wen=%b Start=%b expected 1 0 0 0",
               done, in_ready, Wen, Start);
    end
    Finish = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(32'sd11, 1'b0, 1'b1, 10'd0);
    send(32'sd12, 1'b0, 1'b1, 10'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (count !== 10'd0 || Wen !== 1'b0 || WAddr !== 10'd0) begin
      errors++;
      $display("FAIL reset_mid_async: count=%0d Wen=%b WAddr=%0d expected 0 0 0", count, Wen, WAddr);
    end
    do_reset();
    send(32'sd21, 1'b0, 1'b1, 10'd0);
    send(-32'sd22, 1'b1, 1'b1, 10'd1);
    exp_q.push_back({10'd1023, 32'd2});
    wait_start("reset_mid");
    checks++;
    if (count !== 10'd2) begin
      errors++;
      $display("FAIL reset_mid_count: got %0d expected 2", count);
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_single();
    test_gaps();
    test_finish();
    test_reset_mid();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
